// File: rtl/toast_pkg.sv
// Toast RV32I shared decode definitions: ALU codes, opcodes, funct3,
// writeback selects and the ID/EX payload bundle.
package toast_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SEQ  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_TEST = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        alu_op_e     alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  wb;
        logic        mrd;
        logic        mwr;
        logic [2:0]  f3;
        logic        br;
        logic        inv;
        logic        jmp;
    } id_ex_t;

    // alt is funct7[5] where it selects SUB or SRA
    function automatic alu_op_e alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_e op;
        op = ALU_ADD;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/toast_imm_gen.sv
// Toast immediate generator: I/S/B/U/J extraction, selected by opcode.
module toast_imm_gen
    import toast_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        unique case (instr[6:0])
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{20{instr[31]}}, instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{12{instr[31]}}, instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/toast_id_stage.sv
// Toast RV32I decode stage with registered ID/EX payload.
// Define TOAST_ILLEGAL_TRAP_EN to add the illegal_o trap flag.
module toast_id_stage
    import toast_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        id_ready_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        ex_ready_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_op1_o,
    output logic [31:0] alu_op2_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wr_en_o,
    output logic [1:0]  wb_sel_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [2:0]  funct3_o,
    output logic        branch_o,
    output logic        br_invert_o,
    output logic        jump_o
`ifdef TOAST_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_o
`endif
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
    logic        wr;
    logic        valid_q;
    id_ex_t      d;
    id_ex_t      q;

    assign opc = if_instr_i[6:0];
    assign rd  = if_instr_i[11:7];
    assign f3  = if_instr_i[14:12];
    assign f7  = if_instr_i[31:25];

    assign rs1_addr_o = if_instr_i[19:15];
    assign rs2_addr_o = if_instr_i[24:20];
    assign id_ready_o = ex_ready_i | ~valid_q;

    toast_imm_gen u_imm (
        .instr (if_instr_i),
        .imm   (imm)
    );

    always_comb begin
        d     = '0;
        ill   = 1'b0;
        wr    = 1'b0;
        d.pc  = if_pc_i;
        d.alu = ALU_ADD;
        d.op1 = rs1_data_i;
        d.op2 = imm;
        d.rs2 = rs2_data_i;
        d.imm = imm;
        d.rd  = rd;
        d.f3  = f3;
        d.wb  = WB_ALU;
        unique case (opc)
            OPC_LUI: begin
                d.op1 = '0;
                wr    = 1'b1;
            end
            OPC_AUIPC: begin
                d.op1 = if_pc_i;
                wr    = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                d.op1 = if_pc_i;
                d.op2 = 32'd4;
                d.jmp = 1'b1;
                wr    = 1'b1;
                ill   = (opc == OPC_JALR) && (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                d.op2 = rs2_data_i;
                d.br  = 1'b1;
                unique case (f3)
                    F3_BEQ:  d.alu = ALU_SEQ;
                    F3_BNE:  {d.alu, d.inv} = {ALU_SEQ, 1'b1};
                    F3_BLT:  d.alu = ALU_SLT;
                    F3_BGE:  {d.alu, d.inv} = {ALU_SLT, 1'b1};
                    F3_BLTU: d.alu = ALU_SLTU;
                    F3_BGEU: {d.alu, d.inv} = {ALU_SLTU, 1'b1};
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d.mrd = 1'b1;
                d.wb  = WB_MEM;
                wr    = 1'b1;
                ill   = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d.mwr = 1'b1;
                ill   = (f3 > 3'd2);
            end
            OPC_OPIMM: begin
                d.alu = alu_from_f3(f3, (f3 == F3_SR) & f7[5]);
                wr    = 1'b1;
                ill   = ((f3 == F3_SLL) && (f7 != 7'h00))
                     || ((f3 == F3_SR) && ((f7 & 7'h5f) != 7'h00));
            end
            OPC_OP: begin
                d.op2 = rs2_data_i;
                d.alu = alu_from_f3(f3, f7[5]);
                wr    = 1'b1;
                ill   = (f7 != 7'h00)
                     && !((f7 == 7'h20)
                          && ((f3 == F3_ADD) || (f3 == F3_SR)));
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: ill = 1'b1;
        endcase
        if ((opc == OPC_OPIMM || opc == OPC_OP)
            && (d.alu == ALU_SLT || d.alu == ALU_SLTU))
            d.wb = WB_TEST;
        d.wr = wr && (rd != 5'd0) && !ill;
        // Illegal encodings retire as a NOP
        if (ill) begin
            d.mrd = 1'b0;
            d.mwr = 1'b0;
            d.br  = 1'b0;
            d.jmp = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            valid_q <= 1'b0;
            q       <= '0;
            q.pc    <= RESET_PC;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            q.wr    <= 1'b0;
            q.mrd   <= 1'b0;
            q.mwr   <= 1'b0;
            q.br    <= 1'b0;
            q.jmp   <= 1'b0;
        end else if (id_ready_o) begin
            valid_q <= if_valid_i;
            if (if_valid_i)
                q <= d;
        end
    end

`ifdef TOAST_ILLEGAL_TRAP_EN
    logic ill_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)
            ill_q <= 1'b0;
        else if (flush_i)
            ill_q <= 1'b0;
        else if (id_ready_o && if_valid_i)
            ill_q <= ill;
    end

    assign illegal_o = ill_q;
`endif

    assign ex_valid_o  = valid_q;
    assign ex_pc_o     = q.pc;
    assign alu_ctrl_o  = q.alu;
    assign alu_op1_o   = q.op1;
    assign alu_op2_o   = q.op2;
    assign rs2_data_o  = q.rs2;
    assign imm_o       = q.imm;
    assign rd_addr_o   = q.rd;
    assign reg_wr_en_o = q.wr;
    assign wb_sel_o    = q.wb;
    assign mem_rd_o    = q.mrd;
    assign mem_wr_o    = q.mwr;
    assign funct3_o    = q.f3;
    assign branch_o    = q.br;
    assign br_invert_o = q.inv;
    assign jump_o      = q.jmp;

endmodule
